riscv_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the word-aligned fetch address into instruction memory, and captures the returned instruction into the IF/ID pipeline register. Supports hazard stalls, branch/jump redirects with flush, and misaligned-target detection. Downstream consumer is the decode stage.

---
 rtl/riscv_fetch_stage.sv | 111 +++++++++++
 tb/tb_riscv_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: owns the PC, fetches from instruction memory and fills the IF/ID register.
// Handles stalls, redirect/flush, and halts on a misaligned fetch address until an aligned redirect.
module riscv_fetch_stage #(
    parameter int                         PC_WIDTH_LENGTH   = 32,
    parameter int                         INST_WIDTH_LENGTH = 32,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = '0,
    parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST        = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    output logic [PC_WIDTH_LENGTH-1:0]   if_id_pc,
    output logic [INST_WIDTH_LENGTH-1:0] if_id_inst,
    output logic                         if_id_valid,
    output logic                         misalign_err,
    output logic [PC_WIDTH_LENGTH-1:0]   misalign_addr,
    output logic [31:0]                  fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t                         r_state, w_state_nx;
    logic [PC_WIDTH_LENGTH-1:0]     r_pc, w_pc_nx;
    logic [PC_WIDTH_LENGTH-1:0]     r_if_pc, w_if_pc_nx;
    logic [INST_WIDTH_LENGTH-1:0]   r_if_inst, w_if_inst_nx;
    logic                           r_if_valid, w_if_valid_nx;
    logic                           r_err, w_err_nx;
    logic [PC_WIDTH_LENGTH-1:0]     r_err_addr, w_err_addr_nx;
    logic [31:0]                    r_count, w_count_nx;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_if_pc_nx    = r_if_pc;
        w_if_inst_nx  = r_if_inst;
        w_if_valid_nx = r_if_valid;
        w_err_nx      = r_err;
        w_err_addr_nx = r_err_addr;
        w_count_nx    = r_count;
        case (r_state)
            BOOT: begin
                w_state_nx    = RUN;
                w_if_valid_nx = 1'b0;
            end
            RUN: begin
                if (redirect) begin
                    w_pc_nx       = redirect_pc;
                    w_if_inst_nx  = NOP_INST;
                    w_if_valid_nx = 1'b0;
                end else if (!stall) begin
                    if (r_pc[1:0] != 2'b00) begin
                        w_if_inst_nx  = NOP_INST;
                        w_if_valid_nx = 1'b0;
                        w_err_nx      = 1'b1;
                        w_err_addr_nx = r_pc;
                        w_state_nx    = HALT;
                    end else begin
                        w_if_inst_nx  = imem_inst;
                        w_if_pc_nx    = r_pc;
                        w_if_valid_nx = 1'b1;
                        w_pc_nx       = r_pc + PC_WIDTH_LENGTH'(4);
                        w_count_nx    = r_count + 32'd1;
                    end
                end
            end
            HALT: begin
                w_if_inst_nx  = NOP_INST;
                w_if_valid_nx = 1'b0;
                if (redirect) begin
                    w_pc_nx = redirect_pc;
                    if (redirect_pc[1:0] == 2'b00) w_state_nx = RUN;
                    else w_err_addr_nx = redirect_pc;
                end
            end
            default: w_state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_if_pc    <= w_if_pc_nx;
            r_if_inst  <= w_if_inst_nx;
            r_if_valid <= w_if_valid_nx;
            r_err      <= w_err_nx;
            r_err_addr <= w_err_addr_nx;
            r_count    <= w_count_nx;
        end
    end

    assign imem_pc       = r_pc;
    assign if_id_pc      = r_if_pc;
    assign if_id_inst    = r_if_inst;
    assign if_id_valid   = r_if_valid;
    assign misalign_err  = r_err;
    assign misalign_addr = r_err_addr;
    assign fetch_count   = r_count;
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed scenarios against a small instruction-memory model.
module tb_riscv_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc, imem_pc, imem_inst, if_id_pc, if_id_inst, misalign_addr, fetch_count;
    logic        if_id_valid, misalign_err;
    int          vectors = 0;
    int          miscompares = 0;

    riscv_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_pc(imem_pc), .imem_inst(imem_inst), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .misalign_err(misalign_err), .misalign_addr(misalign_addr),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 32'hDEAD_BEEF;
        case (a)
            32'h0: return 32'h1111_1111;
            32'h4: return 32'h2222_2222;
            32'h8: return 32'h3333_3333;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign imem_inst = mem(imem_pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        chk("rst imem_pc", imem_pc, 32'h0);
        chk("rst if_id_pc", if_id_pc, 32'h0);
        chk("rst if_id_inst", if_id_inst, 32'h13);
        chk("rst valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst err", {31'b0, misalign_err}, 32'h0);
        chk("rst err_addr", misalign_addr, 32'h0);
        chk("rst count", fetch_count, 32'h0);
    endtask

    task automatic test_free_run_stall();
        rst_n = 1'b1;
        tick();
        chk("boot valid", {31'b0, if_id_valid}, 32'h0);
        chk("boot imem_pc", imem_pc, 32'h0);
        tick();
        chk("run0 pc", if_id_pc, 32'h0);
        chk("run0 inst", if_id_inst, 32'h1111_1111);
        chk("run0 valid", {31'b0, if_id_valid}, 32'h1);
        tick();
        chk("run1 pc", if_id_pc, 32'h4);
        chk("run1 inst", if_id_inst, 32'h2222_2222);
        chk("run1 imem_pc", imem_pc, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall imem_pc", imem_pc, 32'h8);
            chk("stall if_id_pc", if_id_pc, 32'h4);
            chk("stall inst", if_id_inst, 32'h2222_2222);
            chk("stall count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("resume pc", if_id_pc, 32'h8);
        chk("resume inst", if_id_inst, 32'h3333_3333);
        chk("resume count", fetch_count, 32'd3);
        chk("resume imem_pc", imem_pc, 32'hC);
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        stall = 1'b0; redirect = 1'b0;
        chk("redir imem_pc", imem_pc, 32'h100);
        chk("redir valid", {31'b0, if_id_valid}, 32'h0);
        chk("redir inst", if_id_inst, 32'h13);
        chk("redir if_id_pc held", if_id_pc, 32'h8);
        chk("redir count", fetch_count, 32'd3);
        tick();
        chk("tgt pc", if_id_pc, 32'h100);
        chk("tgt inst", if_id_inst, 32'h100 ^ 32'hA5A5_0000);
        chk("tgt valid", {31'b0, if_id_valid}, 32'h1);
        chk("tgt count", fetch_count, 32'd4);
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("mis bubble valid", {31'b0, if_id_valid}, 32'h0);
        chk("mis err not yet", {31'b0, misalign_err}, 32'h0);
        tick();
        chk("mis err", {31'b0, misalign_err}, 32'h1);
        chk("mis addr", misalign_addr, 32'h102);
        chk("mis imem_pc", imem_pc, 32'h102);
        chk("mis valid", {31'b0, if_id_valid}, 32'h0);
        chk("mis count", fetch_count, 32'd4);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("halt hold imem_pc", imem_pc, 32'h102);
        redirect = 1'b1; redirect_pc = 32'h301;
        tick();
        redirect = 1'b0;
        chk("halt misredir imem_pc", imem_pc, 32'h301);
        chk("halt misredir addr", misalign_addr, 32'h301);
        tick();
        chk("still halt imem_pc", imem_pc, 32'h301);
        chk("still halt count", fetch_count, 32'd4);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("halt exit imem_pc", imem_pc, 32'h200);
        chk("halt exit valid", {31'b0, if_id_valid}, 32'h0);
        tick();
        chk("post halt pc", if_id_pc, 32'h200);
        chk("post halt valid", {31'b0, if_id_valid}, 32'h1);
        chk("post halt count", fetch_count, 32'd5);
        chk("sticky err", {31'b0, misalign_err}, 32'h1);
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap cap pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap cap inst", if_id_inst, 32'hFFFF_FFFC ^ 32'hA5A5_0000);
        chk("wrap imem_pc", imem_pc, 32'h0);
        chk("wrap count", fetch_count, 32'd6);
        tick();
        chk("wrap next pc", if_id_pc, 32'h0);
        chk("wrap next inst", if_id_inst, 32'h1111_1111);
        chk("wrap next count", fetch_count, 32'd7);
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; redirect_pc = 32'h400; stall = 1'b1; rst_n = 1'b0;
        tick();
        chk("mrst imem_pc", imem_pc, 32'h0);
        chk("mrst if_id_pc", if_id_pc, 32'h0);
        chk("mrst inst", if_id_inst, 32'h13);
        chk("mrst valid", {31'b0, if_id_valid}, 32'h0);
        chk("mrst err", {31'b0, misalign_err}, 32'h0);
        chk("mrst addr", misalign_addr, 32'h0);
        chk("mrst count", fetch_count, 32'h0);
        rst_n = 1'b1; redirect = 1'b0; stall = 1'b0;
        tick();
        chk("mrst boot valid", {31'b0, if_id_valid}, 32'h0);
        tick();
        chk("mrst first pc", if_id_pc, 32'h0);
        chk("mrst first inst", if_id_inst, 32'h1111_1111);
        chk("mrst first count", fetch_count, 32'd1);
    endtask

    initial begin
        test_reset();
        test_free_run_stall();
        test_redirect_over_stall();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
